// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared loader state enumeration and byte/word width constants.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    localparam int C_BYTE_W         = 8;
    localparam int C_WORD_W         = 32;
    localparam int C_BYTES_PER_WORD = C_WORD_W / C_BYTE_W;
    localparam int C_LEN_W          = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN0 = 3'd1,
        ST_LEN1 = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_e;

endpackage
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_packer
// Description : Shifts bytes little-endian into a 32-bit word and flags the
//               cycle on which the fourth byte of a word is taken.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                in_valid,
    input  logic [C_BYTE_W-1:0] in_byte,
    output logic [C_WORD_W-1:0] word,
    output logic                word_done
);

    localparam int C_CNT_W = $clog2(C_BYTES_PER_WORD);

    logic [C_WORD_W-1:0] shift_q, shift_d;
    logic [C_CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        // New bytes enter at the top so the first byte ends up in [7:0]
        word      = {in_byte, shift_q[C_WORD_W-1:C_BYTE_W]};
        word_done = in_valid && (cnt_q == C_CNT_W'(C_BYTES_PER_WORD - 1));
        if (clear) begin
            cnt_d = '0;
        end else if (in_valid) begin
            shift_d = word;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Serial byte-stream program loader for an instruction memory.
//               Optional trailing XOR checksum with IMEM_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          MAX_WORDS = 64
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [C_BYTE_W-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                mem_we,
    output logic [31:0]         mem_addr,
    output logic [C_WORD_W-1:0] mem_wd,
    output logic                cpu_rst,
    output logic                done,
    output logic                err
);

    state_e               state_q, state_d;
    logic [C_LEN_W-1:0]   len_q, len_d;
    logic [C_LEN_W-1:0]   word_cnt_q, word_cnt_d;
    logic                 in_ready_q, in_ready_d;
    logic                 mem_we_q, mem_we_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [C_WORD_W-1:0]  mem_wd_q, mem_wd_d;
    logic                 cpu_rst_q, cpu_rst_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [C_BYTE_W-1:0]  csum_q, csum_d;
    localparam state_e    C_AFTER_PAYLOAD = ST_CSUM;
`else
    localparam state_e    C_AFTER_PAYLOAD = ST_DONE;
`endif

    logic                 w_accept;
    logic [C_LEN_W-1:0]   w_len;
    logic [C_WORD_W-1:0]  w_word;
    logic                 w_word_done;

    assign w_accept = in_valid && in_ready_q;
    assign w_len    = {in_data, len_q[7:0]};

    // Clearing outside DATA drops any partial word after an abort or restart
    byte_packer u_byte_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (state_q != ST_DATA),
        .in_valid  (w_accept && (state_q == ST_DATA)),
        .in_byte   (in_data),
        .word      (w_word),
        .word_done (w_word_done)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d    = ST_LEN0;
                    len_d      = '0;
                    word_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            ST_LEN0: begin
                if (w_accept) begin
                    len_d[7:0] = in_data;
                    state_d    = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (w_accept) begin
                    len_d = w_len;
                    if ({16'd0, w_len} > 32'(MAX_WORDS))
                        state_d = ST_ERR;
                    else if (w_len == '0)
                        state_d = C_AFTER_PAYLOAD;
                    else
                        state_d = ST_DATA;
                end
            end
            ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (w_accept)
                    csum_d = csum_q ^ in_data;
`endif
                if (w_word_done) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = BASE_ADDR + {14'd0, word_cnt_q, 2'b00};
                    mem_wd_d   = w_word;
                    word_cnt_d = word_cnt_q + 16'd1;
                    if (word_cnt_q == len_q - 16'd1)
                        state_d = C_AFTER_PAYLOAD;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (w_accept)
                    state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_LEN0) || (state_d == ST_LEN1) ||
                     (state_d == ST_DATA) || (state_d == ST_CSUM);
        cpu_rst_d  = (state_d != ST_DONE);
        done_d     = (state_d == ST_DONE);
        err_d      = (state_d == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= BASE_ADDR;
            mem_wd_q   <= '0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            in_ready_q <= in_ready_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign in_ready = in_ready_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_wd   = mem_wd_q;
    assign cpu_rst  = cpu_rst_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0, byte address of the first instruction word written.
REQ-002 SHALL have parameter MAX_WORDS, default 64, the largest accepted program length in words.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-005 SHALL have port start, input, 1, single-cycle pulse that begins a load.
REQ-006 SHALL have port in_data, input, 8, serial program byte.
REQ-007 SHALL have port in_valid, input, 1, in_data is valid.
REQ-008 SHALL have port in_ready, output, 1, loader accepts a byte this cycle.
REQ-009 SHALL have port mem_we, output, 1, instruction-memory write strobe.
REQ-010 SHALL have port mem_addr, output, 32, byte address of the word written.
REQ-011 SHALL have port mem_wd, output, 32, word written.
REQ-012 SHALL have port cpu_rst, output, 1, active-high reset to the CPU, held while not DONE.
REQ-013 SHALL have ports done and err, outputs, 1 each, load outcome flags.

Function
REQ-014 SHALL accept a byte exactly on cycles where in_valid && in_ready.
REQ-015 SHALL implement states IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
REQ-016 SHALL drive in_ready=1 only in LEN0, LEN1, DATA, CSUM.
REQ-017 SHALL move IDLE->LEN0 on start; start is ignored in LEN0..CSUM.
REQ-018 SHALL take a 16-bit little-endian word count N: LEN0 low byte, LEN1 high byte.
REQ-019 SHALL go from LEN1 to ERR if N > MAX_WORDS, to DONE (or CSUM if enabled) if N==0, else to DATA.
REQ-020 SHALL assemble each word little-endian: the first byte is bits [7:0].
REQ-021 SHALL, the cycle after the 4th byte of word k is accepted, pulse mem_we for one cycle with mem_addr=BASE_ADDR+4*k and mem_wd=that word.
REQ-022 SHALL keep in_ready=1 during the write cycle so that bytes of word k+1 can be accepted back-to-back.
REQ-023 SHALL leave DATA after word N-1 is written, going to DONE (or CSUM).
REQ-024 SHALL hold mem_addr/mem_wd at their last values when mem_we=0.
REQ-025 SHALL drive cpu_rst=1 in every state except DONE, and done=1 only in DONE, err=1 only in ERR.
REQ-026 SHALL restart (DONE or ERR -> LEN0) on start, clearing done/err the next cycle and raising cpu_rst.

Reset
REQ-027 SHALL, on rst==0 at a clock edge, enter IDLE with in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wd=0, cpu_rst=1, done=0, err=0, and clear counters.
REQ-028 SHALL abort an in-progress load on reset; already-written words stay in memory and no partial word is written.

Configuration
REQ-029 SHALL, with IMEM_LOADER_CHECKSUM_EN defined, expect one CSUM byte after the payload equal to the XOR of all payload bytes (length bytes excluded), entering DONE on match and ERR on mismatch.
REQ-030 SHALL, without IMEM_LOADER_CHECKSUM_EN, have no CSUM state and go directly to DONE after the last word.

Structure
REQ-031 SHALL place the state enumeration and the byte/word width constants in a shared loader package header.
REQ-032 SHALL use one sub-module, byte_packer, that shifts 4 bytes into a 32-bit word and flags word-complete.

Verification
REQ-033 SHALL check: start; bytes 02 00, 63 68 52 00, 63 62 62 00 -> writes 32'h00526863 @0, 32'h00626263 @4; done=1, cpu_rst=0.
REQ-034 SHALL check: length 0x0041 with MAX_WORDS=64 -> ERR, err=1, in_ready=0, no mem_we.
REQ-035 SHALL check: in_valid toggling every other cycle during a 1-word load -> the same single write; byte count is unaffected by the gaps.
REQ-036 SHALL check: rst=0 after 2 bytes of word 1 of a 3-word load -> IDLE, no further mem_we, cpu_rst=1; a new start reloads from BASE_ADDR.
REQ-037 SHALL check (CHECKSUM_EN): 1 word EF BE AD DE, CSUM 0x22 -> DONE; CSUM 0x23 -> ERR with cpu_rst=1.
REQ-038 SHALL check: with BASE_ADDR=32'h100, the second word is written at mem_addr=32'h104.
